// File: rtl/card_lock_pkg.sv
// Shared card-lock definitions: card types, desk ops, default reset code and the code LFSR.
package card_lock_pkg;

    localparam logic [1:0] GUEST       = 2'b00;
    localparam logic [1:0] MAID        = 2'b01;
    localparam logic [1:0] GUEST_RESET = 2'b10;
    localparam logic [1:0] MAID_RESET  = 2'b11;

    localparam logic [1:0] OP_ISSUE_GUEST = 2'd0;
    localparam logic [1:0] OP_ISSUE_MAID  = 2'd1;
    localparam logic [1:0] OP_GUEST_RESET = 2'd2;
    localparam logic [1:0] OP_MAID_RESET  = 2'd3;

    localparam logic [15:0] RESET_CODE_DEFAULT = 16'habcd;

    typedef enum logic {ST_IDLE, ST_PRESENT} enc_state_t;

    // Must match the lock's sequence exactly; a nonzero state never reaches zero.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[4] ^ s[2] ^ s[1]};
    endfunction

endpackage

// File: rtl/card_code_lfsr.sv
// Per-class code sequence: EMPTY/LOADED flag plus last issued code.
// Updates on the cycle after load/advance/clear; clear has priority.
module card_code_lfsr
    import card_lock_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [15:0] seed_i,
    input  logic        advance_i,
    input  logic        clear_i,
    output logic        loaded_o,
    output logic [15:0] next_code_o
);

    logic        loaded_q;
    logic [15:0] last_code_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            loaded_q    <= 1'b0;
            last_code_q <= 16'h0000;
        end else if (clear_i) begin
            loaded_q    <= 1'b0;
            last_code_q <= 16'h0000;
        end else if (load_i) begin
            loaded_q    <= 1'b1;
            last_code_q <= seed_i;
        end else if (advance_i) begin
            last_code_q <= lfsr_next(last_code_q);
        end
    end

    assign loaded_o    = loaded_q;
    assign next_code_o = lfsr_next(last_code_q);

endmodule

// File: rtl/card_code_encoder.sv
// Desk-command to card-image encoder; card presented 1 cycle after command acceptance.
// Holds the card until the writer takes it; no command is accepted meanwhile.
module card_code_encoder
    import card_lock_pkg::*;
#(
    parameter logic [15:0] RESET_CODE = RESET_CODE_DEFAULT,
    parameter int          CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [15:0]      cmd_seed,
    output logic             card_valid,
    input  logic             card_ready,
    output logic [1:0]       card_type,
    output logic [15:0]      entry_code,
    output logic             cmd_error,
    output logic [CNT_W-1:0] guest_count,
    output logic [CNT_W-1:0] maid_count
);

    enc_state_t       state_q;
    logic             card_valid_q;
    logic [1:0]       card_type_q;
    logic [15:0]      entry_code_q;
    logic             cmd_error_q;
    logic [CNT_W-1:0] guest_count_q;
    logic [CNT_W-1:0] maid_count_q;

    logic        accept;
    logic        op_guest, op_maid, op_greset, op_mreset;
    logic        g_loaded, m_loaded, sel_loaded;
    logic [15:0] g_next, m_next, sel_next, issue_code;
    logic        seed_zero, reject;

    assign cmd_ready  = (state_q == ST_IDLE);
    assign accept     = cmd_valid && cmd_ready;
    assign op_guest   = (cmd_op == OP_ISSUE_GUEST);
    assign op_maid    = (cmd_op == OP_ISSUE_MAID);
    assign op_greset  = (cmd_op == OP_GUEST_RESET);
    assign op_mreset  = (cmd_op == OP_MAID_RESET);
    assign sel_loaded = op_maid ? m_loaded : g_loaded;
    assign sel_next   = op_maid ? m_next : g_next;
    assign seed_zero  = (cmd_seed == 16'h0000);
    // An empty class needs a nonzero seed, otherwise the LFSR would lock up at zero.
    assign reject     = (op_guest || op_maid) && !sel_loaded && seed_zero;
    assign issue_code = sel_loaded ? sel_next : cmd_seed;

    card_code_lfsr u_guest (
        .clk_i       (clk),
        .rst_i       (reset),
        .load_i      (accept && op_guest && !g_loaded && !seed_zero),
        .seed_i      (cmd_seed),
        .advance_i   (accept && op_guest && g_loaded),
        .clear_i     (accept && op_greset),
        .loaded_o    (g_loaded),
        .next_code_o (g_next)
    );

    card_code_lfsr u_maid (
        .clk_i       (clk),
        .rst_i       (reset),
        .load_i      (accept && op_maid && !m_loaded && !seed_zero),
        .seed_i      (cmd_seed),
        .advance_i   (accept && op_maid && m_loaded),
        .clear_i     (accept && (op_greset || op_mreset)),
        .loaded_o    (m_loaded),
        .next_code_o (m_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            card_valid_q  <= 1'b0;
            card_type_q   <= GUEST;
            entry_code_q  <= 16'h0000;
            cmd_error_q   <= 1'b0;
            guest_count_q <= '0;
            maid_count_q  <= '0;
        end else begin
            cmd_error_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (reject) begin
                            cmd_error_q <= 1'b1;
                        end else begin
                            state_q      <= ST_PRESENT;
                            card_valid_q <= 1'b1;
                            card_type_q  <= cmd_op;
                            entry_code_q <= (op_greset || op_mreset) ? RESET_CODE : issue_code;
                            if (op_greset) begin
                                guest_count_q <= '0;
                                maid_count_q  <= '0;
                            end
                            if (op_mreset) begin
                                maid_count_q <= '0;
                            end
                        end
                    end
                end
                ST_PRESENT: begin
                    if (card_ready) begin
                        state_q      <= ST_IDLE;
                        card_valid_q <= 1'b0;
                        if (card_type_q == GUEST && guest_count_q != '1) begin
                            guest_count_q <= CNT_W'(guest_count_q + 1'b1);
                        end
                        if (card_type_q == MAID && maid_count_q != '1) begin
                            maid_count_q <= CNT_W'(maid_count_q + 1'b1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign card_valid  = card_valid_q;
    assign card_type   = card_type_q;
    assign entry_code  = entry_code_q;
    assign cmd_error   = cmd_error_q;
    assign guest_count = guest_count_q;
    assign maid_count  = maid_count_q;

endmodule

// File: tb/tb_card_code_encoder.sv
// Directed bench for card_code_encoder with hand-computed card codes.
module tb_card_code_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_seed;
    logic        card_valid;
    logic        card_ready;
    logic [1:0]  card_type;
    logic [15:0] entry_code;
    logic        cmd_error;
    logic [7:0]  guest_count;
    logic [7:0]  maid_count;

    int n_cmp = 0;
    int n_err = 0;

    card_code_encoder #(.RESET_CODE(16'habcd), .CNT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_seed    (cmd_seed),
        .card_valid  (card_valid),
        .card_ready  (card_ready),
        .card_type   (card_type),
        .entry_code  (entry_code),
        .cmd_error   (cmd_error),
        .guest_count (guest_count),
        .maid_count  (maid_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [15:0] seed);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_seed  = seed;
        tick();
        cmd_valid = 1'b0;
        cmd_seed  = 16'h0000;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_seed = 16'h0; card_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        #1;
        n_cmp++; if (card_valid !== 1'b0) begin n_err++; $display("FAIL rst_card_valid got %b want 0", card_valid); end
        n_cmp++; if (card_type !== 2'b00) begin n_err++; $display("FAIL rst_card_type got %b want 00", card_type); end
        n_cmp++; if (entry_code !== 16'h0000) begin n_err++; $display("FAIL rst_entry_code got %h want 0000", entry_code); end
        n_cmp++; if (cmd_error !== 1'b0) begin n_err++; $display("FAIL rst_cmd_error got %b want 0", cmd_error); end
        n_cmp++; if (guest_count !== 8'd0 || maid_count !== 8'd0) begin n_err++; $display("FAIL rst_counts got %0d/%0d want 0/0", guest_count, maid_count); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_cmd_ready got %b want 1", cmd_ready); end
        tick();
    endtask

    task automatic test_guest_issue();
        card_ready = 1'b1;
        issue(2'd0, 16'h1234);
        n_cmp++; if (card_valid !== 1'b1) begin n_err++; $display("FAIL g1_latency card_valid got %b want 1", card_valid); end
        n_cmp++; if (card_type !== 2'b00 || entry_code !== 16'h1234) begin n_err++; $display("FAIL g1_card got %b/%h want 00/1234", card_type, entry_code); end
        n_cmp++; if (guest_count !== 8'd0) begin n_err++; $display("FAIL g1_count_early got %0d want 0", guest_count); end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL g1_cmd_ready got %b want 0", cmd_ready); end
        tick();
        n_cmp++; if (card_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_err++; $display("FAIL g1_done got valid=%b ready=%b want 0/1", card_valid, cmd_ready); end
        n_cmp++; if (guest_count !== 8'd1) begin n_err++; $display("FAIL g1_count got %0d want 1", guest_count); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_code [2];
        exp_code[0] = 16'h2468;
        exp_code[1] = 16'h48D0;
        for (int i = 0; i < 2; i++) begin
            issue(2'd0, 16'hFFFF);
            n_cmp++; if (card_valid !== 1'b1 || entry_code !== exp_code[i]) begin n_err++; $display("FAIL b2b_code[%0d] got v=%b %h want 1 %h", i, card_valid, entry_code, exp_code[i]); end
            tick();
        end
        n_cmp++; if (guest_count !== 8'd3 || maid_count !== 8'd0) begin n_err++; $display("FAIL b2b_counts got %0d/%0d want 3/0", guest_count, maid_count); end
    endtask

    task automatic test_backpressure();
        card_ready = 1'b0;
        issue(2'd0, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            cmd_valid = (i == 1 || i == 2);
            cmd_op    = 2'd1;
            cmd_seed  = 16'h8000;
            n_cmp++; if (card_valid !== 1'b1 || card_type !== 2'b00 || entry_code !== 16'h91A1 || cmd_ready !== 1'b0) begin
                n_err++; $display("FAIL bp_hold[%0d] got v=%b t=%b c=%h r=%b want 1 00 91a1 0", i, card_valid, card_type, entry_code, cmd_ready);
            end
            tick();
        end
        cmd_valid = 1'b0;
        cmd_seed  = 16'h0000;
        card_ready = 1'b1;
        tick();
        n_cmp++; if (card_valid !== 1'b0 || guest_count !== 8'd4 || maid_count !== 8'd0) begin
            n_err++; $display("FAIL bp_release got v=%b g=%0d m=%0d want 0 4 0", card_valid, guest_count, maid_count);
        end
    endtask

    task automatic test_maid_and_guest_reset();
        issue(2'd1, 16'h8000);
        n_cmp++; if (card_type !== 2'b01 || entry_code !== 16'h8000) begin n_err++; $display("FAIL m_seed got %b/%h want 01/8000", card_type, entry_code); end
        tick();
        issue(2'd1, 16'h0000);
        n_cmp++; if (card_type !== 2'b01 || entry_code !== 16'h0001) begin n_err++; $display("FAIL m_wrap got %b/%h want 01/0001", card_type, entry_code); end
        tick();
        n_cmp++; if (maid_count !== 8'd2) begin n_err++; $display("FAIL m_count got %0d want 2", maid_count); end
        issue(2'd2, 16'h5A5A);
        n_cmp++; if (card_valid !== 1'b1 || card_type !== 2'b10 || entry_code !== 16'habcd) begin n_err++; $display("FAIL greset_card got v=%b %b/%h want 1 10/abcd", card_valid, card_type, entry_code); end
        n_cmp++; if (guest_count !== 8'd0 || maid_count !== 8'd0) begin n_err++; $display("FAIL greset_counts got %0d/%0d want 0/0", guest_count, maid_count); end
        tick();
        issue(2'd1, 16'h0000);
        n_cmp++; if (cmd_error !== 1'b1 || card_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_err++; $display("FAIL zero_seed got err=%b v=%b r=%b want 1 0 1", cmd_error, card_valid, cmd_ready); end
        tick();
        n_cmp++; if (cmd_error !== 1'b0 || card_valid !== 1'b0) begin n_err++; $display("FAIL err_pulse got err=%b v=%b want 0 0", cmd_error, card_valid); end
    endtask

    task automatic test_maid_reset();
        issue(2'd1, 16'h5555);
        tick();
        issue(2'd0, 16'h1234);
        tick();
        issue(2'd0, 16'h0000);
        n_cmp++; if (entry_code !== 16'h2468) begin n_err++; $display("FAIL mr_pre got %h want 2468", entry_code); end
        tick();
        issue(2'd3, 16'h0000);
        n_cmp++; if (card_type !== 2'b11 || entry_code !== 16'habcd) begin n_err++; $display("FAIL mreset_card got %b/%h want 11/abcd", card_type, entry_code); end
        n_cmp++; if (guest_count !== 8'd2 || maid_count !== 8'd0) begin n_err++; $display("FAIL mreset_counts got %0d/%0d want 2/0", guest_count, maid_count); end
        tick();
        issue(2'd0, 16'h0000);
        n_cmp++; if (card_type !== 2'b00 || entry_code !== 16'h48D0) begin n_err++; $display("FAIL mr_guest got %b/%h want 00/48d0", card_type, entry_code); end
        tick();
        issue(2'd1, 16'h0000);
        n_cmp++; if (cmd_error !== 1'b1 || card_valid !== 1'b0) begin n_err++; $display("FAIL mr_maid_empty got err=%b v=%b want 1 0", cmd_error, card_valid); end
        tick();
    endtask

    task automatic test_async_reset();
        card_ready = 1'b0;
        issue(2'd0, 16'h0000);
        n_cmp++; if (card_valid !== 1'b1 || entry_code !== 16'h91A1) begin n_err++; $display("FAIL ar_pre got v=%b %h want 1 91a1", card_valid, entry_code); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (card_valid !== 1'b0 || entry_code !== 16'h0000 || guest_count !== 8'd0) begin
            n_err++; $display("FAIL ar_drop got v=%b c=%h g=%0d want 0 0000 0", card_valid, entry_code, guest_count);
        end
        tick();
        reset = 1'b0;
        card_ready = 1'b1;
        tick();
        issue(2'd0, 16'h00FF);
        n_cmp++; if (card_valid !== 1'b1 || entry_code !== 16'h00FF) begin n_err++; $display("FAIL ar_reseed got v=%b %h want 1 00ff", card_valid, entry_code); end
        tick();
    endtask

    task automatic test_saturation();
        card_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            issue(2'd0, 16'h0001);
            tick();
        end
        n_cmp++; if (guest_count !== 8'hFF) begin n_err++; $display("FAIL sat_guest got %0d want 255", guest_count); end
    endtask

    initial begin
        test_reset();
        test_guest_issue();
        test_back_to_back();
        test_backpressure();
        test_maid_and_guest_reset();
        test_maid_reset();
        test_async_reset();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
